onchip_memory_test_master: RTL and testbench

//  Avalon-MM master that drives the single-port on-chip memory slave (32-bit,

---
 rtl/onchip_memory_test_master.sv | 254 +++++++++++++++++++++++++
 tb/tb_onchip_memory_test_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_test_master.sv
// onchip_memory_test_master
// Avalon-MM master for the single-port on-chip RAM. It fills a word range
// with an incrementing pattern (seed + i), reads the range back and checks it,
// or does both back-to-back. Expected data and addresses follow each read
// through a READ_LATENCY-deep pipe so they meet the returning readdata.
module onchip_memory_test_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 10240,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [15:0]           err_count,
  output logic                  first_err_valid,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W-1:0]     readdata,
  output logic                  clken
);

  localparam int BE_W = DATA_W / 8;
  // Depth in a width wide enough to compare base+length without overflow.
  localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECKCFG = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  state_t              state_r;
  logic [1:0]          mode_r;
  logic [ADDR_W-1:0]   base_r;
  logic [ADDR_W:0]     len_r;
  logic [DATA_W-1:0]   seed_r;
  logic [ADDR_W:0]     idx_r;
  logic [DATA_W-1:0]   pat_r;
  logic [1:0]          drain_r;
  logic                busy_r;
  logic                done_r;
  logic                cfg_err_r;
  logic [15:0]         err_count_r;
  logic                first_err_valid_r;
  logic [ADDR_W-1:0]   first_err_addr_r;
  logic [ADDR_W-1:0]   address_r;
  logic                chipselect_r;
  logic                write_r;
  logic [DATA_W-1:0]   writedata_r;

  logic                pipe_v_r    [READ_LATENCY];
  logic [DATA_W-1:0]   pipe_exp_r  [READ_LATENCY];
  logic [ADDR_W-1:0]   pipe_addr_r [READ_LATENCY];

  logic                last_s;
  logic [ADDR_W+1:0]   range_end_s;
  logic                cfg_bad_s;
  logic                mismatch_s;
  logic                clr_results_s;

  // Command bookkeeping: last index, range validation, compare result.
  always_comb begin
    last_s        = (idx_r == (len_r - (ADDR_W+1)'(1)));
    range_end_s   = {2'b00, base_r} + {1'b0, len_r};
    cfg_bad_s     = ({2'b00, base_r} >= DEPTH_X) || (range_end_s > DEPTH_X);
    mismatch_s    = pipe_v_r[READ_LATENCY-1] &&
                    (readdata != pipe_exp_r[READ_LATENCY-1]);
    clr_results_s = (state_r == ST_CHECKCFG) && (len_r != (ADDR_W+1)'(0)) && !cfg_bad_s;
  end

  // Expected-data pipe: each issued read enters stage 0 and emerges with its readdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v_r[i]    <= 1'b0;
        pipe_exp_r[i]  <= '0;
        pipe_addr_r[i] <= '0;
      end
    end else begin
      pipe_v_r[0]    <= chipselect_r && !write_r;
      pipe_exp_r[0]  <= pat_r;
      pipe_addr_r[0] <= address_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_r[i]    <= pipe_v_r[i-1];
        pipe_exp_r[i]  <= pipe_exp_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

  // Check results: cleared when a valid command launches, updated per mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r       <= 16'd0;
      first_err_valid_r <= 1'b0;
      first_err_addr_r  <= '0;
    end else if (clr_results_s) begin
      err_count_r       <= 16'd0;
      first_err_valid_r <= 1'b0;
      first_err_addr_r  <= '0;
    end else if (mismatch_s) begin
      if (err_count_r != 16'hFFFF) begin
        err_count_r <= err_count_r + 16'd1;
      end
      if (!first_err_valid_r) begin
        first_err_valid_r <= 1'b1;
        first_err_addr_r  <= pipe_addr_r[READ_LATENCY-1];
      end
    end
  end

  // Command sequencer with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      mode_r       <= 2'b00;
      base_r       <= '0;
      len_r        <= '0;
      seed_r       <= '0;
      idx_r        <= '0;
      pat_r        <= '0;
      drain_r      <= 2'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      address_r    <= '0;
      chipselect_r <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mode_r    <= mode;
            base_r    <= base;
            len_r     <= length;
            seed_r    <= seed;
            busy_r    <= 1'b1;
            cfg_err_r <= 1'b0;
            state_r   <= ST_CHECKCFG;
          end
        end
        ST_CHECKCFG: begin
          if (len_r == (ADDR_W+1)'(0)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FINISH;
          end else if (cfg_bad_s) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            cfg_err_r <= 1'b1;
            state_r   <= ST_FINISH;
          end else begin
            idx_r        <= '0;
            address_r    <= base_r;
            pat_r        <= seed_r;
            chipselect_r <= 1'b1;
            if (mode_r == 2'b00 || mode_r == 2'b10) begin
              write_r     <= 1'b1;
              writedata_r <= seed_r;
              state_r     <= ST_WRITE;
            end else begin
              write_r <= 1'b0;
              state_r <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (last_s) begin
            write_r <= 1'b0;
            if (mode_r == 2'b10) begin
              // Readback starts on the very next cycle from the range start.
              idx_r     <= '0;
              address_r <= base_r;
              pat_r     <= seed_r;
              state_r   <= ST_READ;
            end else begin
              chipselect_r <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
              state_r      <= ST_FINISH;
            end
          end else begin
            idx_r       <= idx_r + (ADDR_W+1)'(1);
            address_r   <= address_r + ADDR_W'(1);
            pat_r       <= pat_r + DATA_W'(1);
            writedata_r <= pat_r + DATA_W'(1);
          end
        end
        ST_READ: begin
          if (last_s) begin
            chipselect_r <= 1'b0;
            drain_r      <= 2'(READ_LATENCY - 1);
            state_r      <= ST_DRAIN;
          end else begin
            idx_r     <= idx_r + (ADDR_W+1)'(1);
            address_r <= address_r + ADDR_W'(1);
            pat_r     <= pat_r + DATA_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_r == 2'd0) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            drain_r <= drain_r - 2'd1;
          end
        end
        ST_FINISH: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          chipselect_r <= 1'b0;
          write_r      <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign cfg_err         = cfg_err_r;
  assign err_count       = err_count_r;
  assign first_err_valid = first_err_valid_r;
  assign first_err_addr  = first_err_addr_r;
  assign address         = address_r;
  assign byteenable      = {BE_W{1'b1}};
  assign chipselect      = chipselect_r;
  assign write           = write_r;
  assign writedata       = writedata_r;
  assign clken           = 1'b1;

endmodule

// File: tb/tb_onchip_memory_test_master.sv
// Directed bench: two masters (read latency 1 and 2) share the command inputs,
// each talks to its own behavioural RAM whose readback can be corrupted.
module tb_onchip_memory_test_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [13:0] base;
  logic [14:0] length;
  logic [31:0] seed;

  logic        busy1, done1, cfg_err1, fev1, cs1, wr1, clken1;
  logic [15:0] errc1;
  logic [13:0] fea1, addr1;
  logic [3:0]  be1;
  logic [31:0] wd1, rd1;

  logic        busy2, done2, cfg_err2, fev2, cs2, wr2, clken2;
  logic [15:0] errc2;
  logic [13:0] fea2, addr2;
  logic [3:0]  be2;
  logic [31:0] wd2, rd2, rd2_q;

  logic [31:0] mem1 [0:10239];
  logic [31:0] mem2 [0:10239];

  logic        c0_en = 1'b0, c1_en = 1'b0;
  logic [13:0] c0_a = 14'd0, c1_a = 14'd0;

  int checks = 0;
  int failures = 0;

  int   done_cyc [2];
  int   cs_cnt   [2];
  int   wr_cnt   [2];
  int   first_cs [2];
  int   last_cs  [2];
  int   max_addr [2];
  logic busy_k1  [2];
  logic busy_dn  [2];
  logic cfg_dn   [2];
  logic fv_dn    [2];
  logic [15:0] ec_dn [2];
  logic [13:0] fa_dn [2];

  always #5 clk = ~clk;

  onchip_memory_test_master #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base),
    .length(length), .seed(seed), .busy(busy1), .done(done1), .cfg_err(cfg_err1),
    .err_count(errc1), .first_err_valid(fev1), .first_err_addr(fea1),
    .address(addr1), .byteenable(be1), .chipselect(cs1), .write(wr1),
    .writedata(wd1), .readdata(rd1), .clken(clken1)
  );

  onchip_memory_test_master #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base),
    .length(length), .seed(seed), .busy(busy2), .done(done2), .cfg_err(cfg_err2),
    .err_count(errc2), .first_err_valid(fev2), .first_err_addr(fea2),
    .address(addr2), .byteenable(be2), .chipselect(cs2), .write(wr2),
    .writedata(wd2), .readdata(rd2), .clken(clken2)
  );

  function automatic logic [31:0] rdv(input logic [13:0] a, input logic [31:0] d);
    if ((c0_en && a == c0_a) || (c1_en && a == c1_a)) return 32'hDEAD;
    else return d;
  endfunction

  // Behavioural RAMs: latency 1 for the first master, 2 for the second.
  always @(posedge clk) begin
    if (cs1 && wr1) mem1[addr1] <= wd1;
    rd1 <= rdv(addr1, mem1[addr1]);
    if (cs2 && wr2) mem2[addr2] <= wd2;
    rd2_q <= rdv(addr2, mem2[addr2]);
    rd2   <= rd2_q;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int u, input int k, input logic bz, input logic dn,
                     input logic cs, input logic wr, input logic [13:0] a,
                     input logic cfg, input logic [15:0] ec, input logic fv,
                     input logic [13:0] fa);
    if (k == 1) busy_k1[u] = bz;
    if (cs) begin
      cs_cnt[u]++;
      if (first_cs[u] == 0) first_cs[u] = k;
      last_cs[u] = k;
      if (int'(a) > max_addr[u]) max_addr[u] = int'(a);
    end
    if (wr) wr_cnt[u]++;
    if (dn && done_cyc[u] == 0) begin
      done_cyc[u] = k;
      busy_dn[u]  = bz;
      cfg_dn[u]   = cfg;
      ec_dn[u]    = ec;
      fv_dn[u]    = fv;
      fa_dn[u]    = fa;
    end
  endtask

  // Issue one command (start sampled at the end of cycle 0) and watch both masters.
  task automatic run_cmd(input logic [1:0] m, input logic [13:0] b, input logic [14:0] l,
                         input logic [31:0] s, input int extra_at, input int budget);
    for (int u = 0; u < 2; u++) begin
      done_cyc[u] = 0; cs_cnt[u] = 0; wr_cnt[u] = 0;
      first_cs[u] = 0; last_cs[u] = 0; max_addr[u] = 0;
    end
    @(negedge clk);
    mode = m; base = b; length = l; seed = s; start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = (k == extra_at);
      if (k == extra_at) begin
        mode = 2'b00; seed = 32'h5555;
      end
      mon(0, k, busy1, done1, cs1, wr1, addr1, cfg_err1, errc1, fev1, fea1);
      mon(1, k, busy2, done2, cs2, wr2, addr2, cfg_err2, errc2, fev2, fea2);
      if (done_cyc[0] != 0 && done_cyc[1] != 0) break;
    end
    start = 1'b0;
  endtask

  task automatic chk_run(input string t, input int u, input int e_done, input int e_cs,
                         input int e_wr, input int e_first, input logic e_cfg,
                         input int e_err, input logic e_fv, input int e_fa);
    string p;
    p = $sformatf("%s_u%0d", t, u);
    chk({p, "_done_cyc"}, done_cyc[u], e_done);
    chk({p, "_busy_c1"}, busy_k1[u], e_done > 1 ? 1 : 0);
    chk({p, "_busy_done"}, busy_dn[u], 0);
    chk({p, "_cs_cnt"}, cs_cnt[u], e_cs);
    chk({p, "_wr_cnt"}, wr_cnt[u], e_wr);
    chk({p, "_first_cs"}, first_cs[u], e_first);
    chk({p, "_cfg_err"}, cfg_dn[u], e_cfg);
    chk({p, "_err_count"}, ec_dn[u], e_err);
    chk({p, "_fev"}, fv_dn[u], e_fv);
    if (e_fv) chk({p, "_fea"}, fa_dn[u], e_fa);
  endtask

  initial begin
    int dseen;
    reset = 1'b1; start = 1'b0; mode = 2'b00; base = 14'd0; length = 15'd0; seed = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_cfg_err", cfg_err1, 0);
    chk("rst_cs", cs1, 0);
    chk("rst_wr", wr1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_wd", wd1, 0);
    chk("rst_errc", errc1, 0);
    chk("rst_fev", fev1, 0);
    chk("rst_fea", fea1, 0);
    chk("rst_be", be1, 4'hF);
    chk("rst_clken", clken1, 1);
    chk("rst_cs2", cs2, 0);
    reset = 1'b0;

    // Fill 0..3 with 1000..1003.
    run_cmd(2'b00, 14'd0, 15'd4, 32'h1000, 0, 40);
    for (int u = 0; u < 2; u++) chk_run("fill4", u, 6, 4, 4, 2, 0, 0, 0, 0);
    chk("mem1_0", mem1[0], 32'h1000);
    chk("mem1_3", mem1[3], 32'h1003);
    chk("mem2_2", mem2[2], 32'h1002);

    // Clean checks, including an offset base with matching seed.
    run_cmd(2'b01, 14'd0, 15'd4, 32'h1000, 0, 40);
    for (int u = 0; u < 2; u++) chk_run("chk4", u, 7 + u, 4, 0, 2, 0, 0, 0, 0);
    run_cmd(2'b11, 14'd1, 15'd3, 32'h1001, 0, 40);
    for (int u = 0; u < 2; u++) chk_run("chk3_off", u, 6 + u, 3, 0, 2, 0, 0, 0, 0);

    // Corrupted readback at 2, then at 2 and 3.
    c0_en = 1'b1; c0_a = 14'd2;
    run_cmd(2'b01, 14'd0, 15'd4, 32'h1000, 0, 40);
    for (int u = 0; u < 2; u++) chk_run("corr1", u, 7 + u, 4, 0, 2, 0, 1, 1, 2);
    c1_en = 1'b1; c1_a = 14'd3;
    run_cmd(2'b01, 14'd0, 15'd4, 32'h1000, 0, 40);
    for (int u = 0; u < 2; u++) chk_run("corr2", u, 7 + u, 4, 0, 2, 0, 2, 1, 2);
    c0_en = 1'b0; c1_en = 1'b0;

    // Wrong seed: every word mismatches, first at the range start.
    run_cmd(2'b01, 14'd0, 15'd4, 32'h0FFF, 0, 40);
    for (int u = 0; u < 2; u++) chk_run("badseed", u, 7 + u, 4, 0, 2, 0, 4, 1, 0);

    // Reset in the middle of a fill.
    @(negedge clk);
    mode = 2'b00; base = 14'd200; length = 15'd8; seed = 32'hABCD; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_cs_c2", cs1, 1);
    chk("mid_wr_c2", wr1, 1);
    chk("mid_addr_c2", addr1, 200);
    chk("mid_wd_c2", wd1, 32'hABCD);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rstmid_cs1", cs1, 0);
    chk("rstmid_cs2", cs2, 0);
    chk("rstmid_wr1", wr1, 0);
    chk("rstmid_busy1", busy1, 0);
    chk("rstmid_errc1", errc1, 0);
    chk("rstmid_fev1", fev1, 0);
    reset = 1'b0;
    dseen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done1 || done2 || cs1 || cs2) dseen++;
    end
    chk("rstmid_no_done", dseen, 0);

    // Range rejection and zero length.
    run_cmd(2'b01, 14'd10239, 15'd2, 32'd0, 0, 20);
    for (int u = 0; u < 2; u++) chk_run("cfg_over", u, 2, 0, 0, 0, 1, 0, 0, 0);
    run_cmd(2'b00, 14'd10240, 15'd1, 32'd0, 0, 20);
    for (int u = 0; u < 2; u++) chk_run("cfg_base", u, 2, 0, 0, 0, 1, 0, 0, 0);
    run_cmd(2'b10, 14'd5, 15'd0, 32'd0, 0, 20);
    for (int u = 0; u < 2; u++) chk_run("len0", u, 2, 0, 0, 0, 0, 0, 0, 0);

    // Top-of-memory fill with pattern wrap, then verify.
    run_cmd(2'b00, 14'd10238, 15'd2, 32'hFFFF_FFFF, 0, 20);
    for (int u = 0; u < 2; u++) chk_run("top_fill", u, 4, 2, 2, 2, 0, 0, 0, 0);
    chk("top_max_addr", max_addr[0], 10239);
    chk("mem1_10238", mem1[10238], 32'hFFFF_FFFF);
    chk("mem2_10239", mem2[10239], 32'h0);
    run_cmd(2'b01, 14'd10238, 15'd2, 32'hFFFF_FFFF, 0, 20);
    for (int u = 0; u < 2; u++) chk_run("top_chk", u, 5 + u, 2, 0, 2, 0, 0, 0, 0);

    // Long fill-then-check to the last word.
    run_cmd(2'b10, 14'd100, 15'd10140, 32'd0, 0, 20400);
    for (int u = 0; u < 2; u++) begin
      chk_run("long", u, 20283 + u, 20280, 10140, 2, 0, 0, 0, 0);
      chk($sformatf("long_last_cs_u%0d", u), last_cs[u], 20281);
      chk($sformatf("long_max_addr_u%0d", u), max_addr[u], 10239);
    end
    chk("long_mem1_5000", mem1[5000], 32'd4900);

    // Start pulsed while busy is ignored.
    run_cmd(2'b01, 14'd0, 15'd4, 32'h1000, 3, 40);
    for (int u = 0; u < 2; u++) chk_run("busy_start", u, 7 + u, 4, 0, 2, 0, 0, 0, 0);
    chk("busy_start_mem", mem1[0], 32'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
